dict_loader: RTL and testbench



---
 rtl/dict_loader_pkg.sv | 44 ++++
 rtl/dict_loader_addr_gen.sv | 55 +++++
 rtl/dict_loader.sv | 216 +++++++++++++++++++++
 tb/tb_dict_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dict_loader_pkg.sv
// Shared definitions for the dictionary loader and the compression controller:
// FSM encoding, width extraction helpers and image layout helpers.
package dict_loader_pkg;

  localparam int unsigned MAX_DICTS       = 4;
  localparam int unsigned DEF_NUM_DICTS   = 3;
  localparam logic [31:0] DEF_KEY_WIDTHS  = 32'h0008_0503;
  localparam logic [31:0] DEF_VAL_WIDTHS  = 32'h000F_0A07;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Width of a dictionary-select index for n dictionaries.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Key width of dictionary d (byte d of the packed width vector).
  function automatic int unsigned key_w(input logic [31:0] widths, input int unsigned d);
    return 32'(widths[8*d +: 8]);
  endfunction

  // Value width of dictionary d (byte d of the packed width vector).
  function automatic int unsigned val_w(input logic [31:0] widths, input int unsigned d);
    return 32'(widths[8*d +: 8]);
  endfunction

  // Image entry offset of dictionary d: sum of 2^key over all earlier dictionaries.
  function automatic int unsigned dict_offset(input logic [31:0] widths, input int unsigned d);
    int unsigned off = 0;
    for (int unsigned j = 0; j < d; j++) begin
      off = off + (32'd1 << key_w(widths, j));
    end
    return off;
  endfunction

  localparam int unsigned TOTAL_ENTRIES = dict_offset(DEF_KEY_WIDTHS, DEF_NUM_DICTS);

endpackage

// File: rtl/dict_loader_addr_gen.sv
// Dictionary/entry counters and image read address for the dictionary loader.
module dict_loader_addr_gen
  import dict_loader_pkg::*;
#(
  parameter int unsigned            NUM_DICTS       = 3,
  parameter logic [8*NUM_DICTS-1:0] DICT_KEY_WIDTHS = {8'd8, 8'd5, 8'd3},
  parameter int unsigned            MAX_KEY_WIDTH   = 8,
  parameter logic [31:0]            BASE_ADDR       = 32'h0001_0000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        restart,
  input  logic                        advance,
  output logic [idx_w(NUM_DICTS)-1:0] dict_idx,
  output logic [MAX_KEY_WIDTH-1:0]    entry_idx,
  output logic                        last_entry_c,
  output logic                        last_dict_c,
  output logic [31:0]                 mem_addr
);

  localparam int unsigned DW = idx_w(NUM_DICTS);

  // Last entry of the currently selected dictionary.
  always_comb begin
    last_entry_c = 1'b0;
    for (int unsigned i = 0; i < NUM_DICTS; i++) begin
      if (dict_idx == DW'(i)) begin
        last_entry_c = (entry_idx ==
          MAX_KEY_WIDTH'((64'd1 << key_w(32'(DICT_KEY_WIDTHS), i)) - 64'd1));
      end
    end
  end

  assign last_dict_c = (dict_idx == DW'(NUM_DICTS - 1));

  // Step (dict, entry) and the word address once per written entry; address wraps mod 2^32.
  always_ff @(posedge clk) begin
    if (!resetn || restart) begin
      dict_idx  <= '0;
      entry_idx <= '0;
      mem_addr  <= BASE_ADDR;
    end else if (advance) begin
      mem_addr <= mem_addr + 32'd4;
      if (last_entry_c) begin
        entry_idx <= '0;
        if (!last_dict_c) begin
          dict_idx <= dict_idx + DW'(1);
        end
      end else begin
        entry_idx <= entry_idx + MAX_KEY_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/dict_loader.sv
// Post-reset sequencer that fills the field dictionaries from instruction
// memory and holds the core in reset until the load completes.
// Optional build macro DICT_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// read and the checksum_err output.
module dict_loader
  import dict_loader_pkg::*;
#(
  parameter int unsigned            NUM_DICTS       = 3,
  parameter logic [8*NUM_DICTS-1:0] DICT_KEY_WIDTHS = {8'd8, 8'd5, 8'd3},
  parameter logic [8*NUM_DICTS-1:0] DICT_VAL_WIDTHS = {8'd15, 8'd10, 8'd7},
  parameter int unsigned            MAX_KEY_WIDTH   = 8,
  parameter int unsigned            MAX_VAL_WIDTH   = 15,
  parameter logic [31:0]            BASE_ADDR       = 32'h0001_0000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     reload,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  input  logic [31:0]              mem_rdata,
  output logic [NUM_DICTS-1:0]     dict_we,
  output logic [MAX_KEY_WIDTH-1:0] dict_index,
  output logic [MAX_VAL_WIDTH-1:0] dict_val,
  output logic                     done,
  output logic                     core_resetn
`ifdef DICT_LOADER_CHECKSUM_EN
  ,
  output logic                     checksum_err
`endif
);

  localparam int unsigned DW = idx_w(NUM_DICTS);

  state_t                   state_q, state_d;
  logic                     mem_valid_d;
  logic [NUM_DICTS-1:0]     dict_we_d;
  logic [MAX_KEY_WIDTH-1:0] dict_index_d;
  logic [MAX_VAL_WIDTH-1:0] dict_val_d;
  logic                     done_d;
  logic                     restart_c;
  logic                     advance_c;
  logic                     handshake_c;
  logic [MAX_VAL_WIDTH-1:0] val_mask_c;
  logic [DW-1:0]            dict_idx;
  logic [MAX_KEY_WIDTH-1:0] entry_idx;
  logic                     last_entry_c;
  logic                     last_dict_c;

`ifdef DICT_LOADER_CHECKSUM_EN
  logic [31:0] xor_q, xor_d;
  logic [31:0] chk_word_q, chk_word_d;
  logic        chk_phase_q, chk_phase_d;
  logic        checksum_err_d;
`endif

  assign handshake_c = mem_valid && mem_ready;

  dict_loader_addr_gen #(
    .NUM_DICTS       (NUM_DICTS),
    .DICT_KEY_WIDTHS (DICT_KEY_WIDTHS),
    .MAX_KEY_WIDTH   (MAX_KEY_WIDTH),
    .BASE_ADDR       (BASE_ADDR)
  ) u_addr_gen (
    .clk          (clk),
    .resetn       (resetn),
    .restart      (restart_c),
    .advance      (advance_c),
    .dict_idx     (dict_idx),
    .entry_idx    (entry_idx),
    .last_entry_c (last_entry_c),
    .last_dict_c  (last_dict_c),
    .mem_addr     (mem_addr)
  );

  // Value mask for the dictionary currently being loaded.
  always_comb begin
    val_mask_c = '0;
    for (int unsigned i = 0; i < NUM_DICTS; i++) begin
      if (dict_idx == DW'(i)) begin
        val_mask_c = MAX_VAL_WIDTH'((64'd1 << val_w(32'(DICT_VAL_WIDTHS), i)) - 64'd1);
      end
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    mem_valid_d  = 1'b0;
    dict_we_d    = '0;
    dict_index_d = '0;
    dict_val_d   = '0;
    done_d       = 1'b0;
    restart_c    = 1'b0;
    advance_c    = 1'b0;
`ifdef DICT_LOADER_CHECKSUM_EN
    xor_d          = xor_q;
    chk_word_d     = chk_word_q;
    chk_phase_d    = chk_phase_q;
    checksum_err_d = checksum_err;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d     = ST_REQ;
        mem_valid_d = 1'b1;
        restart_c   = 1'b1;
`ifdef DICT_LOADER_CHECKSUM_EN
        xor_d       = '0;
        chk_phase_d = 1'b0;
`endif
      end
      ST_REQ: begin
        mem_valid_d = 1'b1;
        if (handshake_c) begin
          state_d      = ST_WRITE;
          mem_valid_d  = 1'b0;
          dict_we_d    = NUM_DICTS'(1) << dict_idx;
          dict_index_d = entry_idx;
          dict_val_d   = MAX_VAL_WIDTH'(mem_rdata) & val_mask_c;
`ifdef DICT_LOADER_CHECKSUM_EN
          xor_d        = xor_q ^ mem_rdata;
`endif
        end
      end
      ST_WRITE: begin
        advance_c = 1'b1;
        if (last_entry_c && last_dict_c) begin
`ifdef DICT_LOADER_CHECKSUM_EN
          state_d     = ST_CHECK;
          mem_valid_d = 1'b1;
          chk_phase_d = 1'b0;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d     = ST_REQ;
          mem_valid_d = 1'b1;
        end
      end
`ifdef DICT_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        // Phase 0 reads the stored checksum word, phase 1 compares it.
        if (!chk_phase_q) begin
          mem_valid_d = 1'b1;
          if (handshake_c) begin
            mem_valid_d = 1'b0;
            chk_word_d  = mem_rdata;
            chk_phase_d = 1'b1;
          end
        end else if (chk_word_q == xor_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          checksum_err_d = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        done_d = 1'b1;
        if (reload) begin
          state_d     = ST_REQ;
          done_d      = 1'b0;
          mem_valid_d = 1'b1;
          restart_c   = 1'b1;
`ifdef DICT_LOADER_CHECKSUM_EN
          xor_d       = '0;
          chk_phase_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; core_resetn follows done so it rises on the same edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mem_valid   <= 1'b0;
      dict_we     <= '0;
      dict_index  <= '0;
      dict_val    <= '0;
      done        <= 1'b0;
      core_resetn <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid   <= mem_valid_d;
      dict_we     <= dict_we_d;
      dict_index  <= dict_index_d;
      dict_val    <= dict_val_d;
      done        <= done_d;
      core_resetn <= done_d;
    end
  end

`ifdef DICT_LOADER_CHECKSUM_EN
  // Running XOR, captured checksum word and sticky error flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      xor_q        <= '0;
      chk_word_q   <= '0;
      chk_phase_q  <= 1'b0;
      checksum_err <= 1'b0;
    end else begin
      xor_q        <= xor_d;
      chk_word_q   <= chk_word_d;
      chk_phase_q  <= chk_phase_d;
      checksum_err <= checksum_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_dict_loader.sv
// Directed bench for dict_loader: image word n = n, zero-wait and slow memory,
// reload, mid-load reset and masking of the first word.
module tb_dict_loader;
  import dict_loader_pkg::*;

  localparam logic [31:0] BASE    = 32'h0001_0000;
  localparam int          NENT    = 296;
  localparam int          BUDGET  = 8 * TOTAL_ENTRIES + 100;
`ifdef DICT_LOADER_CHECKSUM_EN
  localparam int          DONE_Z  = 595;
  localparam int          DONE_W3 = 1189;
`else
  localparam int          DONE_Z  = 593;
  localparam int          DONE_W3 = 1185;
`endif

  logic        clk;
  logic        resetn;
  logic        reload;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [2:0]  dict_we;
  logic [7:0]  dict_index;
  logic [14:0] dict_val;
  logic        done;
  logic        core_resetn;
`ifdef DICT_LOADER_CHECKSUM_EN
  logic        checksum_err;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 1;
  int          wait_cnt = 0;
  bit          ovr      = 1'b0;
  logic [31:0] chk_word = '0;
  bit          err_seen = 1'b0;

  dict_loader u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .reload      (reload),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .dict_we     (dict_we),
    .dict_index  (dict_index),
    .dict_val    (dict_val),
    .done        (done),
    .core_resetn (core_resetn)
`ifdef DICT_LOADER_CHECKSUM_EN
    ,
    .checksum_err(checksum_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image: word n holds n; optional all-ones word 0; checksum word after the last entry.
  function automatic logic [31:0] img_word(input logic [31:0] addr, input bit ovr_i,
                                           input logic [31:0] chk_i);
    logic [31:0] n;
    n = (addr - BASE) >> 2;
    if (ovr_i && n == 32'd0) return 32'hFFFF_FFFF;
    if (n == 32'(NENT)) return chk_i;
    return n;
  endfunction

  function automatic logic [31:0] img_xor(input bit ovr_i);
    logic [31:0] x = '0;
    for (int n = 0; n < NENT; n++) x = x ^ img_word(BASE + 32'(4 * n), ovr_i, 32'd0);
    return x;
  endfunction

  assign mem_rdata = img_word(mem_addr, ovr, chk_word);
  assign mem_ready = mem_valid && (wait_cnt >= lat - 1);

  always @(posedge clk) begin
    if (!resetn || !mem_valid || mem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rst(input string pfx);
    check({pfx, "_valid"}, 64'(mem_valid), 64'd0);
    check({pfx, "_addr"}, 64'(mem_addr), 64'(BASE));
    check({pfx, "_we"}, 64'(dict_we), 64'd0);
    check({pfx, "_idx"}, 64'(dict_index), 64'd0);
    check({pfx, "_val"}, 64'(dict_val), 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_core_rst"}, 64'(core_resetn), 64'd0);
  endtask

  // Follow one load, checking every request and write; cycle 1 is the first request cycle.
  task automatic run_load(input int lat_i, input bit reload_first, input int reload_at,
                          input int abort_n, input int exp_done);
    int          cyc   = 0;
    int          n     = 0;
    int          d, k;
    bit          started = 1'b0;
    bit          seen    = 1'b0;
    bit          early   = 1'b0;
    bit          pv      = 1'b0;
    bit          phs     = 1'b0;
    logic [31:0] paddr   = '0;
    logic [31:0] vmask;
    lat = lat_i;
    if (reload_first) reload = 1'b1;
    for (int t = 0; t < BUDGET; t++) begin
      @(posedge clk);
      #1;
      reload = 1'b0;
      if (!started && mem_valid) started = 1'b1;
      if (started) cyc++;
      if (cyc == reload_at) reload = 1'b1;
      if (reload_first && cyc == 1) begin
        check("reload_done_drop", 64'(done), 64'd0);
        check("reload_core_rst_drop", 64'(core_resetn), 64'd0);
      end
      if (abort_n >= 0 && mem_valid && n == abort_n) return;
      if (mem_valid) begin
        if (pv && !phs) check("addr_stable", 64'(mem_addr), 64'(paddr));
        else check("req_addr", 64'(mem_addr), 64'(BASE + 32'(4 * n)));
      end else if (pv && !phs) begin
        check("valid_held", 64'(mem_valid), 64'd1);
      end
      if (dict_we != 3'b000) begin
        d = (n < 8) ? 0 : (n < 40) ? 1 : 2;
        k = n - ((d == 0) ? 0 : (d == 1) ? 8 : 40);
        vmask = (d == 0) ? 32'h7F : (d == 1) ? 32'h3FF : 32'h7FFF;
        check("write_we", 64'(dict_we), 64'(3'(1) << d));
        check("write_idx", 64'(dict_index), 64'(k));
        check("write_val", 64'(dict_val),
              64'(img_word(BASE + 32'(4 * n), ovr, chk_word) & vmask));
        check("write_no_req", 64'(mem_valid), 64'd0);
        if (n == 295) check("d2_e255_val", 64'(dict_val), 64'h127);
        if (ovr && n == 0) check("ovr_first", 64'({dict_we, dict_index, dict_val}),
                                 64'({3'b001, 8'h00, 15'h007F}));
        n++;
      end
      if (done) begin
        check("done_cycle", 64'(cyc), 64'(exp_done));
        check("core_rst_with_done", 64'(core_resetn), 64'd1);
        check("n_writes", 64'(n), 64'(NENT));
        check("no_early_release", 64'(early), 64'd0);
`ifdef DICT_LOADER_CHECKSUM_EN
        check("chk_err_clear", 64'(checksum_err), 64'd0);
`endif
        seen = 1'b1;
        break;
      end
      if (core_resetn) early = 1'b1;
      pv    = mem_valid;
      phs   = mem_valid && mem_ready;
      paddr = mem_addr;
    end
    if (abort_n < 0 && !seen) check("done_timeout", 64'd0, 64'd1);
    if (abort_n >= 0) check("abort_point_reached", 64'd0, 64'd1);
  endtask

  initial begin
    resetn   = 1'b0;
    reload   = 1'b0;
    chk_word = img_xor(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_rst("rst");
    resetn = 1'b1;

    run_load(1, 1'b0, -1, -1, DONE_Z);
    run_load(1, 1'b1, -1, -1, DONE_Z);
    run_load(3, 1'b1, -1, -1, DONE_W3);
    run_load(1, 1'b1, 100, -1, DONE_Z);

    // Reset during dict 1 entry 10 (entry 18), then a fresh load.
    run_load(1, 1'b1, -1, 18, DONE_Z);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_rst("abort");
    resetn = 1'b1;
    run_load(1, 1'b0, -1, -1, DONE_Z);

    ovr      = 1'b1;
    chk_word = img_xor(1'b1);
    run_load(1, 1'b1, -1, -1, DONE_Z);

`ifdef DICT_LOADER_CHECKSUM_EN
    resetn   = 1'b0;
    ovr      = 1'b0;
    lat      = 1;
    chk_word = ~img_xor(1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int t = 0; t < BUDGET; t++) begin
      @(posedge clk);
      #1;
      if (checksum_err) begin
        err_seen = 1'b1;
        break;
      end
    end
    check("chk_err_seen", 64'(err_seen), 64'd1);
    check("chk_err_done", 64'(done), 64'd0);
    check("chk_err_core_rst", 64'(core_resetn), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("chk_err_sticky", 64'(checksum_err), 64'd1);
    check("chk_err_core_rst_held", 64'(core_resetn), 64'd0);
    check("chk_err_no_req", 64'(mem_valid), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
